drum_audio_drain: RTL and testbench
===================================

Name: drum_audio_drain

Overview:
- Consumer end of the drum-grid sample path.
- Requests grid updates with a start_update pulse and waits for done_update.
- Captures center_node_amp into a small first-word-fall-through (FWFT) FIFO.
- Drains the FIFO to the audio output as sign-extended, scaled left/right samples over a valid/ready handshake.
- Back-pressures the grid: no update is requested unless a FIFO slot is guaranteed.

Parameters:
- DEPTH, 8, FIFO entries; power of 2, minimum 2.
- SAMPLE_W, 18, grid amplitude width (signed 1.17).
- AUDIO_W, 32, audio sample width.
- AUDIO_SHIFT, 14, left shift applied after sign-extension (18-bit full scale maps to 32-bit full scale).
- TIMEOUT, 65535, maximum cycles spent in WAIT_DONE before abort.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- enable  in  1  allows new update requests.
- center_node_amp  in  SAMPLE_W  signed grid center amplitude.
- done_update  in  1  grid update-complete indication.
- start_update  out  1  one-cycle update request to the grid.
- audio_ready  in  1  audio sink accepts a sample.
- audio_valid  out  1  FIFO head is valid.
- audio_left  out  AUDIO_W  scaled FIFO head sample.
- audio_right  out  AUDIO_W  same value as audio_left.
- fifo_level  out  $clog2(DEPTH)+1  current occupancy.
- timeout_err  out  1  sticky; set when a WAIT_DONE timeout occurs.

Behaviour:
- Reset (asynchronous, reset_n=0):
  - FSM goes to IDLE.
  - FIFO is emptied.
  - start_update=0, audio_valid=0, audio_left/right=0, fifo_level=0, timeout_err=0, watchdog counter=0.
- FSM states:
  - IDLE: if enable=1 and fifo_level<DEPTH, go to REQUEST.
  - REQUEST: start_update=1 for exactly this one cycle; go to WAIT_DONE; clear the watchdog.
  - WAIT_DONE: the watchdog increments each cycle.
    - done_update=1: go to CAPTURE.
    - Watchdog reaches TIMEOUT: set timeout_err and go to IDLE.
  - CAPTURE: push center_node_amp into the FIFO (the grid registers its center value one cycle after done_update); go to IDLE.
- One request is in flight at a time. Because IDLE checks for a free slot and only this block pushes, CAPTURE can never overflow the FIFO.
- enable deasserted in REQUEST or WAIT_DONE: the outstanding request completes and its sample is captured; no new request is issued.
- Request throughput: at most one sample per (3 + grid latency) cycles.
- Output side (FWFT):
  - audio_valid = (fifo_level != 0).
  - audio_left/right present the head combinationally from the registered FIFO storage.
  - Pop occurs when audio_valid && audio_ready.
  - audio_ready while empty: no pop, no effect.
- Simultaneous push and pop: fifo_level is unchanged; the pushed data is ordered after the head.
- Pointers are $clog2(DEPTH) bits wide and wrap naturally. fifo_level is tracked separately, so full and empty are unambiguous.
- Scaling: output = sign_extend(sample, AUDIO_W) <<< AUDIO_SHIFT. There is no saturation: 18+14=32 cannot overflow.
- When empty, audio_left/right hold the last popped value, or 0 after reset.
- timeout_err is cleared only by reset.

Optional Feature:
- Macro: DRUM_DRAIN_UNDERRUN_CNT_EN.
- When defined:
  - Adds output underrun_count[15:0], reset to 0.
  - The counter increments each cycle audio_ready=1 while fifo_level=0.
  - It saturates at 16'hFFFF.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package drum_audio_pkg holds:
  - SAMPLE_W and AUDIO_W defaults.
  - The FSM state encoding: IDLE=2'd0, REQUEST=2'd1, WAIT_DONE=2'd2, CAPTURE=2'd3.
  - The scaling function sign-extend-and-shift.
- Sub-module sample_fifo, parameterised by DEPTH and SAMPLE_W:
  - Ports: push, pop, wdata, rdata, level.
- drum_audio_drain contains the FSM, the watchdog, scaling and the optional counter.

Test Plan:
- Grid model with done_update 10 cycles after start_update, returning amp 18'h0_8000; sink ready=1. Required response:
  - start_update pulses exactly 1 cycle.
  - audio_valid rises 2 cycles after done_update, with audio_left=32'h2000_0000.
  - Repeats steadily.
- Sink ready=0, enable=1. Required response:
  - fifo_level climbs to 8 and start_update stops.
  - Raise ready: 8 samples drain in order; requests resume when fifo_level=7.
- Negative sample 18'h3_FFFF (-1 LSB). Required response: audio_left=audio_right=32'hFFFF_C000.
- TIMEOUT=20 with a grid that never asserts done_update. Required response:
  - timeout_err=1 at cycle 21 of WAIT_DONE; FSM returns to IDLE and re-requests.
  - timeout_err stays set until reset_n=0.
- With FIFO level 4, ready=1 and a concurrent CAPTURE: fifo_level stays 4; the output order matches push order. Then deassert enable during WAIT_DONE: exactly one more sample is captured and no further start_update occurs.
- Assert reset_n=0 mid-WAIT_DONE with FIFO level 3: all outputs are 0 immediately (asynchronously). After release, the first start_update occurs 2 cycles later when enable=1.
- With DRUM_DRAIN_UNDERRUN_CNT_EN defined, hold ready=1 with an empty FIFO for 5 cycles: underrun_count=5.

Source files
------------

// File: rtl/drum_audio_pkg.sv
// Shared definitions for the drum-grid audio drain: default widths, FSM state
// encoding and the sample scaling helper.
package drum_audio_pkg;

    localparam int SAMPLE_W_DEF    = 18;
    localparam int AUDIO_W_DEF     = 32;
    localparam int AUDIO_SHIFT_DEF = 14;

    // Wide enough for any sign-extended sample shifted into any audio width.
    localparam int SCALE_W = 64;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        REQUEST   = 2'd1,
        WAIT_DONE = 2'd2,
        CAPTURE   = 2'd3
    } drain_state_e;

    // The caller sign-extends the sample into SCALE_W bits and keeps the low
    // audio bits of the result.
    function automatic logic signed [SCALE_W-1:0] scale_sample(
        input logic signed [SCALE_W-1:0] sample,
        input int unsigned               shift
    );
        return sample <<< shift;
    endfunction

endpackage

// File: rtl/drum_audio_drain_fifo.sv
// First-word-fall-through sample FIFO: the head entry is visible on rdata
// whenever level is non-zero. Occupancy is counted separately from the pointers.
module sample_fifo
    import drum_audio_pkg::*;
#(
    parameter int DEPTH    = 8,
    parameter int SAMPLE_W = SAMPLE_W_DEF
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [SAMPLE_W-1:0]      wdata,
    output logic [SAMPLE_W-1:0]      rdata,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [SAMPLE_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;
    logic                do_push;
    logic                do_pop;

    // A pop in the same cycle frees the slot a full-FIFO push would need.
    assign do_pop  = pop && (level != '0);
    assign do_push = push && ((level != LVL_W'(DEPTH)) || do_pop);

    // NOTE: the storage array has no reset; level gates every read, so stale
    // contents are never observed and the array can map onto plain RAM cells.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

    assign rdata = mem[rd_ptr];

endmodule

// File: rtl/drum_audio_drain.sv
// Consumer end of the drum-grid sample path: requests grid updates, captures the
// center amplitude into a FWFT FIFO and drains it as scaled stereo audio.
// Optional underrun counter: define DRUM_DRAIN_UNDERRUN_CNT_EN.
module drum_audio_drain
    import drum_audio_pkg::*;
#(
    parameter int DEPTH       = 8,
    parameter int SAMPLE_W    = SAMPLE_W_DEF,
    parameter int AUDIO_W     = AUDIO_W_DEF,
    parameter int AUDIO_SHIFT = AUDIO_SHIFT_DEF,
    parameter int TIMEOUT     = 65535
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       enable,
    input  logic [SAMPLE_W-1:0]        center_node_amp,
    input  logic                       done_update,
    output logic                       start_update,
    input  logic                       audio_ready,
    output logic                       audio_valid,
    output logic [AUDIO_W-1:0]         audio_left,
    output logic [AUDIO_W-1:0]         audio_right,
    output logic [$clog2(DEPTH):0]     fifo_level,
    output logic                       timeout_err
`ifdef DRUM_DRAIN_UNDERRUN_CNT_EN
   ,output logic [15:0]                underrun_count
`endif
);

    localparam int LVL_W = $clog2(DEPTH) + 1;
    localparam int WD_W  = $clog2(TIMEOUT + 1);

    drain_state_e        state;
    drain_state_e        state_nxt;
    logic [WD_W-1:0]     wd_cnt;
    logic                wd_clr;
    logic                wd_inc;
    logic                err_set;
    logic                push;
    logic                pop;
    logic                fifo_full;
    logic [SAMPLE_W-1:0] fifo_rdata;
    logic [AUDIO_W-1:0]  head_scaled;
    logic [AUDIO_W-1:0]  last_popped;

    sample_fifo #(
        .DEPTH    (DEPTH),
        .SAMPLE_W (SAMPLE_W)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (push),
        .pop     (pop),
        .wdata   (center_node_amp),
        .rdata   (fifo_rdata),
        .level   (fifo_level)
    );

    assign fifo_full = (fifo_level == LVL_W'(DEPTH));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Only one request is ever in flight and IDLE demands a free slot, so the
    // CAPTURE push always has room.
    // NOTE: every output of this block is given a default before the case,
    // so no path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_nxt    = state;
        start_update = 1'b0;
        wd_clr       = 1'b0;
        wd_inc       = 1'b0;
        err_set      = 1'b0;
        push         = 1'b0;
        case (state)
            IDLE: begin
                if (enable && !fifo_full) begin
                    state_nxt = REQUEST;
                end
            end
            REQUEST: begin
                start_update = 1'b1;
                wd_clr       = 1'b1;
                state_nxt    = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (done_update) begin
                    state_nxt = CAPTURE;
                end else if (wd_cnt == WD_W'(TIMEOUT)) begin
                    err_set   = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    wd_inc = 1'b1;
                end
            end
            CAPTURE: begin
                // The grid presents its registered center value this cycle.
                push      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wd_cnt      <= '0;
            timeout_err <= 1'b0;
        end else begin
            if (wd_clr) begin
                wd_cnt <= '0;
            end else if (wd_inc) begin
                wd_cnt <= wd_cnt + WD_W'(1);
            end
            if (err_set) begin
                timeout_err <= 1'b1;
            end
        end
    end

    assign audio_valid = (fifo_level != '0);
    assign pop         = audio_valid && audio_ready;

    // 18-bit full scale lands on 32-bit full scale, so no saturation is needed.
    assign head_scaled = AUDIO_W'(scale_sample(SCALE_W'($signed(fifo_rdata)), AUDIO_SHIFT));

    // Holds the most recently drained sample so the outputs stay put when empty.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_popped <= '0;
        end else if (pop) begin
            last_popped <= head_scaled;
        end
    end

    assign audio_left  = audio_valid ? head_scaled : last_popped;
    assign audio_right = audio_left;

`ifdef DRUM_DRAIN_UNDERRUN_CNT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            underrun_count <= '0;
        end else if (audio_ready && !audio_valid && (underrun_count != 16'hFFFF)) begin
            underrun_count <= underrun_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_drum_audio_drain.sv
// Self-checking bench for drum_audio_drain: a grid model answers requests, and a
// queue-based reference model predicts occupancy and the drained audio stream.
module tb_drum_audio_drain;

    logic        clk;
    logic        reset_n;
    logic        enable;
    logic [17:0] center_node_amp;
    logic        done_update;
    logic        start_update;
    logic        audio_ready;
    logic        audio_valid;
    logic [31:0] audio_left;
    logic [31:0] audio_right;
    logic [3:0]  fifo_level;
    logic        timeout_err;
`ifdef DRUM_DRAIN_UNDERRUN_CNT_EN
    logic [15:0] underrun_count;
`endif

    drum_audio_drain #(
        .DEPTH       (8),
        .SAMPLE_W    (18),
        .AUDIO_W     (32),
        .AUDIO_SHIFT (14),
        .TIMEOUT     (20)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .enable          (enable),
        .center_node_amp (center_node_amp),
        .done_update     (done_update),
        .start_update    (start_update),
        .audio_ready     (audio_ready),
        .audio_valid     (audio_valid),
        .audio_left      (audio_left),
        .audio_right     (audio_right),
        .fifo_level      (fifo_level),
        .timeout_err     (timeout_err)
`ifdef DRUM_DRAIN_UNDERRUN_CNT_EN
       ,.underrun_count  (underrun_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int          grid_lat = 10;   // 0: grid never answers
    int          amp_mode = 0;    // 0: 0x08000, 1: random, 2: -1 LSB
    bit          chk_on   = 0;
    bit          cap_now  = 0;
    logic [17:0] cap_amp  = '0;
    logic [17:0] m_q [$];
    logic [31:0] m_last   = '0;

    function automatic logic [31:0] ref_scale(input logic [17:0] s);
        int v;
        v = int'($signed(s));
        return 32'(v * 16384);
    endfunction

    function automatic logic [17:0] pick_amp();
        case (amp_mode)
            0:       return 18'h0_8000;
            2:       return 18'h3_FFFF;
            default: return 18'($urandom);
        endcase
    endfunction

    // Grid: done_update grid_lat cycles after start_update, value one cycle later.
    initial begin
        int          cd;
        bit          pend;
        bit          prev_start;
        logic [17:0] nxt;
        cd = 0; pend = 0; prev_start = 0; nxt = '0;
        done_update = 1'b0;
        center_node_amp = '0;
        forever begin
            @(negedge clk);
            done_update     = 1'b0;
            cap_now         = 1'b0;
            center_node_amp = 18'($urandom);
            if (!reset_n) begin
                cd = 0; pend = 0; prev_start = 0;
            end else begin
                if (pend) begin
                    center_node_amp = nxt;
                    cap_amp         = nxt;
                    cap_now         = 1'b1;
                    pend            = 0;
                end
                if (cd > 0) begin
                    cd--;
                    if (cd == 0) begin
                        done_update = 1'b1;
                        pend        = 1;
                        nxt         = pick_amp();
                    end
                end
                if (start_update) begin
                    check("start_width", 32'(prev_start), 0);
                    if (grid_lat > 0) cd = grid_lat;
                end
                prev_start = start_update;
            end
        end
    end

    // FIFO/sink model: pop the head when the sink is ready, append captures.
    initial begin
        forever begin
            @(posedge clk or negedge reset_n);
            if (!reset_n) begin
                m_q.delete();
                m_last = '0;
            end else begin
                if (m_q.size() != 0 && audio_ready) m_last = ref_scale(m_q.pop_front());
                if (cap_now) m_q.push_back(cap_amp);
            end
        end
    end

    // Cycle-by-cycle comparison against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (chk_on) begin
                check("level", 32'(fifo_level), 32'(m_q.size()));
                check("valid", 32'(audio_valid), 32'(m_q.size() != 0));
                check("left",  audio_left,  (m_q.size() != 0) ? ref_scale(m_q[0]) : m_last);
                check("right", audio_right, (m_q.size() != 0) ? ref_scale(m_q[0]) : m_last);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "time limit");
    end

    // ---------------- helpers ----------------
    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic wait_start(input string tag, input int budget);
        int n;
        n = 0;
        @(negedge clk);
        while (!start_update && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(start_update), 1);
    endtask

    task automatic wait_level(input string tag, input int target, input int budget);
        int n;
        n = 0;
        @(negedge clk);
        while (int'(fifo_level) != target && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(fifo_level), 32'(target));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int starts;
        reset_n     = 1'b0;
        enable      = 1'b0;
        audio_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_level", 32'(fifo_level), 0);
        check("rst_valid", 32'(audio_valid), 0);
        check("rst_left",  audio_left, 0);
        check("rst_start", 32'(start_update), 0);
        check("rst_err",   32'(timeout_err), 0);
        reset_n = 1'b1;
        chk_on  = 1;

        // Steady stream, fixed amplitude, sink always ready.
        amp_mode = 0; grid_lat = 10; audio_ready = 1'b1; enable = 1'b1;
        do_reset();
        repeat (3) begin
            wait_start("s1_start", 20);
            @(negedge clk);
            check("s1_pulse_end", 32'(start_update), 0);
            repeat (10) @(negedge clk);
            check("s1_valid_early", 32'(audio_valid), 0);
            @(negedge clk);
            check("s1_valid", 32'(audio_valid), 1);
            check("s1_left", audio_left, 32'h2000_0000);
        end

        // Back-pressure: fill to DEPTH, requests stop, resume at level 7.
        amp_mode = 1; grid_lat = 3; audio_ready = 1'b0; enable = 1'b1;
        do_reset();
        wait_level("s2_full", 8, 200);
        starts = 0;
        repeat (30) begin
            @(negedge clk);
            starts += int'(start_update);
        end
        check("s2_no_req_full", 32'(starts), 0);
        audio_ready = 1'b1;
        @(negedge clk);
        check("s2_level7", 32'(fifo_level), 7);
        check("s2_no_req_yet", 32'(start_update), 0);
        @(negedge clk);
        check("s2_resume", 32'(start_update), 1);
        repeat (30) @(negedge clk);

        // Negative full-resolution sample.
        amp_mode = 2; grid_lat = 2; audio_ready = 1'b0; enable = 1'b1;
        do_reset();
        wait_level("s3_one", 1, 40);
        enable = 1'b0;
        check("s3_left",  audio_left,  32'hFFFF_C000);
        check("s3_right", audio_right, 32'hFFFF_C000);

        // Watchdog: grid never answers.
        amp_mode = 1; grid_lat = 0; audio_ready = 1'b1; enable = 1'b1;
        do_reset();
        wait_start("s4_start", 20);
        repeat (21) @(negedge clk);
        check("s4_err_not_yet", 32'(timeout_err), 0);
        @(negedge clk);
        check("s4_err_set", 32'(timeout_err), 1);
        wait_start("s4_rearm", 4);
        grid_lat = 10;
        repeat (60) @(negedge clk);
        check("s4_err_sticky", 32'(timeout_err), 1);
        enable = 1'b0;
        do_reset();
        check("s4_err_cleared", 32'(timeout_err), 0);

        // Push and pop in the same cycle at level 4, then enable drop mid-request.
        amp_mode = 1; grid_lat = 4; audio_ready = 1'b0; enable = 1'b1;
        do_reset();
        wait_level("s5_level4", 4, 100);
        wait_start("s5_start", 10);
        repeat (5) @(negedge clk);
        audio_ready = 1'b1;
        @(negedge clk);
        audio_ready = 1'b0;
        check("s5_level_same", 32'(fifo_level), 4);
        wait_start("s5_start2", 10);
        @(negedge clk);
        enable = 1'b0;
        starts = 0;
        repeat (40) begin
            @(negedge clk);
            starts += int'(start_update);
        end
        check("s5_no_new_req", 32'(starts), 0);
        check("s5_one_more", 32'(fifo_level), 5);
        audio_ready = 1'b1;
        repeat (10) @(negedge clk);
        check("s5_drained", 32'(fifo_level), 0);

        // Asynchronous reset in WAIT_DONE with three samples queued.
        amp_mode = 1; grid_lat = 10; audio_ready = 1'b0; enable = 1'b1;
        do_reset();
        wait_level("s6_level3", 3, 100);
        wait_start("s6_start", 10);
        repeat (3) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("s6_async_level", 32'(fifo_level), 0);
        check("s6_async_valid", 32'(audio_valid), 0);
        check("s6_async_left",  audio_left, 0);
        check("s6_async_right", audio_right, 0);
        check("s6_async_start", 32'(start_update), 0);
        check("s6_async_err",   32'(timeout_err), 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("s6_first_req", 32'(start_update), 1);

        // Randomized traffic against the model.
        amp_mode = 1;
        do_reset();
        repeat (600) begin
            @(negedge clk);
            audio_ready = 1'($urandom_range(0, 2) != 0);
            enable      = 1'($urandom_range(0, 7) != 0);
            grid_lat    = int'($urandom_range(1, 6));
        end
        enable = 1'b0;
        audio_ready = 1'b1;
        repeat (30) @(negedge clk);
        check("s7_final_empty", 32'(fifo_level), 0);

`ifdef DRUM_DRAIN_UNDERRUN_CNT_EN
        enable = 1'b0; audio_ready = 1'b0;
        do_reset();
        check("s8_underrun_rst", 32'(underrun_count), 0);
        audio_ready = 1'b1;
        repeat (5) @(negedge clk);
        audio_ready = 1'b0;
        check("s8_underrun_5", 32'(underrun_count), 5);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
